// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------------------------
// disp_pkg
//   Shared constants and helpers for the multiplexed 7-segment display driver.
//   - SEG_0 .. SEG_F : active-low segment patterns, bit 6 = segment a ... bit 0 = segment g
//   - SEG_OFF        : all segments dark
//   - scan_state_e   : scan FSM state encoding (DRIVE, GAP)
//   - seg_decode()   : nibble -> segment pattern; BCD mode returns SEG_OFF for codes above 9
// ---------------------------------------------------------------------------------------------
package disp_pkg;

    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b1100000;
    localparam logic [6:0] SEG_C   = 7'b0110001;
    localparam logic [6:0] SEG_D   = 7'b1000010;
    localparam logic [6:0] SEG_E   = 7'b0110000;
    localparam logic [6:0] SEG_F   = 7'b0111000;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        DRIVE,
        GAP
    } scan_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] code, input logic hex_mode);
        logic [6:0] seg;
        seg = SEG_OFF;
        unique case (code)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
        // BCD mode: codes A..F are not digits and stay dark
        if (!hex_mode && (code > 4'd9)) begin
            seg = SEG_OFF;
        end
        return seg;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// ---------------------------------------------------------------------------------------------
// seg_decoder
//   Combinational nibble to 7-segment decoder (active-low segments).
//   Ports:
//     code_i      in  4  digit code
//     hex_mode_i  in  1  1 = decode 0-F, 0 = BCD (codes above 9 are invalid)
//     seg_o       out 7  segment pattern a..g in [6:0], SEG_OFF when invalid
//     valid_o     out 1  1 = code is displayable in the selected mode
// ---------------------------------------------------------------------------------------------
module seg_decoder
    import disp_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       hex_mode_i,
    output logic [6:0] seg_o,
    output logic       valid_o
);

    assign seg_o   = seg_decode(code_i, hex_mode_i);
    assign valid_o = hex_mode_i || (code_i <= 4'd9);

endmodule

// File: rtl/display_scan_mux.sv
// ---------------------------------------------------------------------------------------------
// display_scan_mux
//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits. A packed digit frame is
//   captured into shadow registers once per scan frame (when the digit index wraps to 0), so input
//   changes mid-frame never tear the display. Leading-zero suppression is resolved at capture.
//   An optional ghost-blanking gap of BLANK_TICKS scan ticks separates consecutive digits.
//
//   Parameters:
//     NUM_DIGITS   digits scanned (2..16)
//     SCAN_DIV     clk1kHz cycles per scan tick (>=1)
//     BLANK_TICKS  all-anodes-off ticks between digits (0..15)
//     BLINK_TICKS  scan ticks per blink half-period (blink build only)
//
//   Ports:
//     clk1kHz     in   1            scan clock
//     reset       in   1            asynchronous, active-high
//     digits_i    in   4*N          digit k at [4k+3:4k], digit 0 rightmost
//     dp_i        in   N            decimal point request, 1 = lit
//     blank_i     in   N            1 = digit forced dark
//     hex_mode_i  in   1            1 = hex decode, 0 = BCD
//     lz_en_i     in   1            1 = suppress leading zeros
//     blink_i     in   N            per-digit blink mask
//     Sseg        out  7            segments a..g, active-low
//     dp_o        out  1            decimal point, active-low
//     anodos      out  N            digit enables, active-low, at most one low
//     frame_o     out  1            one-cycle pulse after a new frame is captured
//
//   Build option: define DISP_BLINK_EN to enable the blink phase counter; otherwise blink_i is
//   ignored and no digit ever blinks.
// ---------------------------------------------------------------------------------------------
module display_scan_mux
    import disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned SCAN_DIV    = 1,
    parameter int unsigned BLANK_TICKS = 0,
    parameter int unsigned BLINK_TICKS = 250
) (
    input  logic                    clk1kHz,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    hex_mode_i,
    input  logic                    lz_en_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    output logic [6:0]              Sseg,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   anodos,
    output logic                    frame_o
);

    localparam int unsigned IdxW    = $clog2(NUM_DIGITS);
    localparam int unsigned IdxLast = NUM_DIGITS - 1;
    localparam int unsigned DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DivLast = SCAN_DIV - 1;
    localparam int unsigned GapLast = (BLANK_TICKS == 0) ? 0 : BLANK_TICKS - 1;

    // Prescaler and scan state
    logic [DivW-1:0]         div_q;
    logic                    tick;
    scan_state_e             state_q;
    logic [IdxW-1:0]         idx_q;
    logic [IdxW-1:0]         idx_next;
    logic [3:0]              gap_q;
    logic                    advance;
    logic                    wrap;

    // Shadow frame
    logic [4*NUM_DIGITS-1:0] sh_digits_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q;
    logic [NUM_DIGITS-1:0]   sh_blank_q;
    logic [NUM_DIGITS-1:0]   sh_lz_q;
    logic                    sh_hex_q;
    logic [NUM_DIGITS-1:0]   lz_mask_d;

    // Output path
    logic [3:0]              cur_code;
    logic [6:0]              dec_seg;
    logic                    dec_valid;
    logic                    blink_dark;
    logic                    lit;
    logic [6:0]              sseg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   anodos_d;

    // -----------------------------------------------------------------------------------------
    // Prescaler: tick in the cycle where the count reaches SCAN_DIV-1
    // -----------------------------------------------------------------------------------------
    assign tick = (div_q == DivLast[DivW-1:0]);

    always_ff @(posedge clk1kHz or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Digit advance: from DRIVE directly when there is no gap, otherwise at the end of GAP
    // -----------------------------------------------------------------------------------------
    always_comb begin
        advance = 1'b0;
        if (tick) begin
            if (state_q == DRIVE) begin
                advance = (BLANK_TICKS == 0);
            end else begin
                advance = (gap_q == GapLast[3:0]);
            end
        end
        wrap     = advance && (idx_q == IdxLast[IdxW-1:0]);
        idx_next = wrap ? '0 : idx_q + 1'b1;
    end

    // -----------------------------------------------------------------------------------------
    // Leading-zero mask, evaluated on the live inputs and stored with the frame.
    // Walk from the most significant digit down; any nonzero code or a dp request ends the run.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        logic supp;
        lz_mask_d = '0;
        supp      = lz_en_i;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if ((digits_i[4*k +: 4] != 4'd0) || dp_i[k]) begin
                supp = 1'b0;
            end
            lz_mask_d[k] = supp;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Optional blink phase
    // -----------------------------------------------------------------------------------------
`ifdef DISP_BLINK_EN
    localparam int unsigned BlinkW    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned BlinkLast = BLINK_TICKS - 1;

    logic [BlinkW-1:0]     blink_cnt_q;
    logic                  phase_q;
    logic [NUM_DIGITS-1:0] sh_blink_q;

    always_ff @(posedge clk1kHz or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            sh_blink_q  <= '0;
        end else begin
            if (tick) begin
                if (blink_cnt_q == BlinkLast[BlinkW-1:0]) begin
                    blink_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
            if (wrap) begin
                sh_blink_q <= blink_i;
            end
        end
    end

    assign blink_dark = phase_q & sh_blink_q[idx_q];
`else
    localparam int unsigned unused_blink_ticks = BLINK_TICKS;
    logic unused_blink;
    assign unused_blink = ^blink_i;
    assign blink_dark   = 1'b0;
`endif

    // -----------------------------------------------------------------------------------------
    // Current digit decode and next output values
    // -----------------------------------------------------------------------------------------
    assign cur_code = sh_digits_q[{idx_q, 2'b00} +: 4];

    seg_decoder u_seg_decoder (
        .code_i     (cur_code),
        .hex_mode_i (sh_hex_q),
        .seg_o      (dec_seg),
        .valid_o    (dec_valid)
    );

    assign lit = (state_q == DRIVE) && !sh_blank_q[idx_q] && !sh_lz_q[idx_q] && dec_valid &&
                 !blink_dark;

    always_comb begin
        sseg_d   = SEG_OFF;
        dp_d     = 1'b1;
        anodos_d = '1;
        if (lit) begin
            sseg_d          = dec_seg;
            dp_d            = ~sh_dp_q[idx_q];
            anodos_d[idx_q] = 1'b0;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Scan FSM, shadow frame and registered outputs
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk1kHz or posedge reset) begin
        if (reset) begin
            state_q     <= DRIVE;
            idx_q       <= '0;
            gap_q       <= '0;
            sh_digits_q <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '1;  // first frame dark until a real capture
            sh_lz_q     <= '0;
            sh_hex_q    <= 1'b0;
            Sseg        <= SEG_OFF;
            dp_o        <= 1'b1;
            anodos      <= '1;
            frame_o     <= 1'b0;
        end else begin
            Sseg    <= sseg_d;
            dp_o    <= dp_d;
            anodos  <= anodos_d;
            frame_o <= wrap;

            unique case (state_q)
                DRIVE: begin
                    if (tick) begin
                        if (BLANK_TICKS == 0) begin
                            idx_q <= idx_next;
                        end else begin
                            state_q <= GAP;
                            gap_q   <= '0;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_q == GapLast[3:0]) begin
                            idx_q   <= idx_next;
                            state_q <= DRIVE;
                        end else begin
                            gap_q <= gap_q + 4'd1;
                        end
                    end
                end
                default: state_q <= DRIVE;
            endcase

            if (wrap) begin
                sh_digits_q <= digits_i;
                sh_dp_q     <= dp_i;
                sh_blank_q  <= blank_i;
                sh_lz_q     <= lz_mask_d;
                sh_hex_q    <= hex_mode_i;
            end
        end
    end

endmodule
